// File: rtl/game_pkg.sv
// Shared types and constants for the two-player turn scheduler.
package game_pkg;

    localparam int COORD_W = 5;

    typedef enum logic [2:0] {
        IDLE,
        LAUNCH,
        WAIT_RES,
        SCORE,
        OVER
    } state_e;

    localparam logic [COORD_W-1:0] TARGET_Y = '0;

endpackage

// File: rtl/shot_watchdog.sv
// Cycle counter that flags a missing calculator result after TIMEOUT cycles.
module shot_watchdog #(
    parameter int TIMEOUT = 255
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt_q, cnt_d;

    // Fires in the TIMEOUT-th enabled cycle so the owner leaves on that edge.
    assign expired_o = en_i && (cnt_q == CW'(TIMEOUT - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && !expired_o) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/turn_scheduler.sv
// Alternating-turn controller sharing one trajectory calculator between players.
module turn_scheduler
    import game_pkg::*;
#(
    parameter int WIN_SCORE = 3,
    parameter int TIMEOUT   = 255,
    localparam int SW       = $clog2(WIN_SCORE + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               new_game,
    input  logic               p0_fire,
    input  logic               p1_fire,
    input  logic [COORD_W-1:0] p0_xpos,
    input  logic [COORD_W-1:0] p1_xpos,
    input  logic [COORD_W-1:0] p0_rise,
    input  logic [COORD_W-1:0] p1_rise,
    input  logic [COORD_W-1:0] p0_run,
    input  logic [COORD_W-1:0] p1_run,
    input  logic               p0_dir,
    input  logic               p1_dir,
    output logic [COORD_W-1:0] tc_xpos,
    output logic [COORD_W-1:0] tc_rise,
    output logic [COORD_W-1:0] tc_run,
    output logic [COORD_W-1:0] tc_target_x,
    output logic [COORD_W-1:0] tc_target_y,
    output logic               tc_dir,
    output logic               tc_shoot,
    input  logic               tc_valid,
    input  logic               tc_hit,
    input  logic [COORD_W-1:0] tc_posx,
    output logic               turn,
    output logic               busy,
    output logic [COORD_W-1:0] last_posx,
    output logic               last_hit,
    output logic [SW-1:0]      score0,
    output logic [SW-1:0]      score1,
    output logic               game_over,
    output logic               winner
);

    state_e               state_q, state_d;
    logic                 turn_q, turn_d;
    logic                 winner_q, winner_d;
    logic                 last_hit_q, last_hit_d;
    logic [COORD_W-1:0]   last_posx_q, last_posx_d;
    logic [SW-1:0]        score0_q, score0_d;
    logic [SW-1:0]        score1_q, score1_d;
    logic [COORD_W-1:0]   xpos_q, xpos_d;
    logic [COORD_W-1:0]   rise_q, rise_d;
    logic [COORD_W-1:0]   run_q, run_d;
    logic [COORD_W-1:0]   tgt_q, tgt_d;
    logic                 dir_q, dir_d;

    logic                 wd_clr;
    logic                 wd_en;
    logic                 wd_expired;
    logic                 cur_fire;
    logic [SW-1:0]        cur_score;
    logic [SW-1:0]        inc_score;

    shot_watchdog #(
        .TIMEOUT(TIMEOUT)
    ) u_watchdog (
        .clk_i    (clk),
        .rst_ni   (rst),
        .clr_i    (wd_clr),
        .en_i     (wd_en),
        .expired_o(wd_expired)
    );

    assign cur_fire  = turn_q ? p1_fire : p0_fire;
    assign cur_score = turn_q ? score1_q : score0_q;
    assign inc_score = cur_score + 1'b1;

    always_comb begin
        state_d     = state_q;
        turn_d      = turn_q;
        winner_d    = winner_q;
        last_hit_d  = last_hit_q;
        last_posx_d = last_posx_q;
        score0_d    = score0_q;
        score1_d    = score1_q;
        xpos_d      = xpos_q;
        rise_d      = rise_q;
        run_d       = run_q;
        tgt_d       = tgt_q;
        dir_d       = dir_q;
        wd_clr      = 1'b0;
        wd_en       = 1'b0;

        if (new_game) begin
            state_d     = IDLE;
            turn_d      = 1'b0;
            winner_d    = 1'b0;
            last_hit_d  = 1'b0;
            last_posx_d = '0;
            score0_d    = '0;
            score1_d    = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (cur_fire) begin
                        state_d = LAUNCH;
                        xpos_d  = turn_q ? p1_xpos : p0_xpos;
                        rise_d  = turn_q ? p1_rise : p0_rise;
                        run_d   = turn_q ? p1_run  : p0_run;
                        dir_d   = turn_q ? p1_dir  : p0_dir;
                        tgt_d   = turn_q ? p0_xpos : p1_xpos;
                    end
                end
                LAUNCH: begin
                    wd_clr  = 1'b1;
                    state_d = WAIT_RES;
                end
                WAIT_RES: begin
                    wd_en = 1'b1;
                    // A result arriving on the timeout cycle still counts.
                    if (tc_valid) begin
                        last_hit_d  = tc_hit;
                        last_posx_d = tc_posx;
                        state_d     = SCORE;
                    end else if (wd_expired) begin
                        last_hit_d  = 1'b0;
                        last_posx_d = '0;
                        state_d     = SCORE;
                    end
                end
                SCORE: begin
                    state_d = IDLE;
                    turn_d  = ~turn_q;
                    if (last_hit_q && (cur_score < SW'(WIN_SCORE))) begin
                        if (turn_q) begin
                            score1_d = inc_score;
                        end else begin
                            score0_d = inc_score;
                        end
                        if (inc_score == SW'(WIN_SCORE)) begin
                            state_d  = OVER;
                            turn_d   = turn_q;
                            winner_d = turn_q;
                        end
                    end
                end
                OVER: begin
                    state_d = OVER;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            turn_q      <= 1'b0;
            winner_q    <= 1'b0;
            last_hit_q  <= 1'b0;
            last_posx_q <= '0;
            score0_q    <= '0;
            score1_q    <= '0;
            xpos_q      <= '0;
            rise_q      <= '0;
            run_q       <= '0;
            tgt_q       <= '0;
            dir_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            turn_q      <= turn_d;
            winner_q    <= winner_d;
            last_hit_q  <= last_hit_d;
            last_posx_q <= last_posx_d;
            score0_q    <= score0_d;
            score1_q    <= score1_d;
            xpos_q      <= xpos_d;
            rise_q      <= rise_d;
            run_q       <= run_d;
            tgt_q       <= tgt_d;
            dir_q       <= dir_d;
        end
    end

    assign tc_xpos     = xpos_q;
    assign tc_rise     = rise_q;
    assign tc_run      = run_q;
    assign tc_dir      = dir_q;
    assign tc_target_x = tgt_q;
    assign tc_target_y = TARGET_Y;
    assign tc_shoot    = (state_q == LAUNCH);
    assign busy        = (state_q == LAUNCH) || (state_q == WAIT_RES) ||
                         (state_q == SCORE);
    assign game_over   = (state_q == OVER);
    assign winner      = winner_q;
    assign turn        = turn_q;
    assign last_hit    = last_hit_q;
    assign last_posx   = last_posx_q;
    assign score0      = score0_q;
    assign score1      = score1_q;

endmodule

// File: doc/turn_scheduler.md
# turn_scheduler

Two-player turn controller that shares the single trajectory calculator between both players. It accepts a fire request only from the player whose turn it is and latches that player's aim. It then launches one shot, waits for the calculator's result (with a watchdog), scores the outcome and alternates turns until one player reaches the winning score.

## Interface

Parameters:
- WIN_SCORE, 3, hits needed to win; score width SW = $clog2(WIN_SCORE+1)
- TIMEOUT, 255, cycles to wait for tc_valid before scoring a miss (≥1)

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-low (0 = reset)
- new_game  in  1  synchronous restart, level-sampled
- p0_fire, p1_fire  in  1  fire request per player, sampled each cycle
- p0_xpos, p1_xpos  in  5  player cannon positions
- p0_rise, p1_rise  in  5  aim rise per player
- p0_run, p1_run  in  5  aim run per player
- p0_dir, p1_dir  in  1  aim direction per player
- tc_xpos, tc_rise, tc_run, tc_target_x, tc_target_y  out  5  calculator operands
- tc_dir  out  1  calculator direction
- tc_shoot  out  1  one-cycle launch pulse
- tc_valid  in  1  calculator result strobe
- tc_hit  in  1  calculator hit flag, qualified by tc_valid
- tc_posx  in  5  calculator landing x, qualified by tc_valid
- turn  out  1  player allowed to fire
- busy  out  1  shot in flight (LAUNCH, WAIT_RES or SCORE)
- last_posx  out  5  landing x of the most recent shot
- last_hit  out  1  hit flag of the most recent shot
- score0, score1  out  SW  per-player scores
- game_over  out  1  high in OVER
- winner  out  1  valid while game_over

## Operation

States: IDLE, LAUNCH, WAIT_RES, SCORE, OVER.
- IDLE: transitions to LAUNCH when the current player's fire is high (p0_fire if turn=0, else p1_fire).
  - The other player's fire is ignored.
  - On that edge, latch the current player's xpos, rise, run and dir into the tc_* registers.
  - tc_target_x = opponent's xpos, sampled on the same edge. tc_target_y = 0.
- LAUNCH: tc_shoot=1 for exactly this cycle. Clear the watchdog counter. Go to WAIT_RES.
- WAIT_RES: count cycles.
  - tc_valid=1: latch last_hit←tc_hit and last_posx←tc_posx, then go to SCORE.
  - Counter reaches TIMEOUT with no valid: last_hit←0, last_posx←0, go to SCORE.
  - tc_valid takes priority over timeout when both occur in the same cycle.
- SCORE: if last_hit, increment the current player's score.
  - If the incremented score equals WIN_SCORE, go to OVER with winner←turn; turn stays unchanged.
  - Otherwise toggle turn and return to IDLE.
- OVER: all fire requests are ignored. Hold until new_game.
- new_game=1 in any state, on the next edge:
  - state→IDLE, scores→0, turn→0, last_hit→0, last_posx→0, game_over→0.
  - tc_* operands are left unchanged; tc_shoot→0.
  - new_game beats a fire request in the same cycle.
- tc_valid outside WAIT_RES is ignored, so a late result after a timeout is discarded.
- tc_* operands are held stable from LAUNCH until the next accepted fire.
- Scores never exceed WIN_SCORE and never wrap.

Reset (rst=0, asynchronous):
- state IDLE; turn, busy, tc_shoot, game_over, winner, last_hit all 0.
- score0, score1, last_posx, all tc_* outputs 0.
- Reset deasserted mid-shot restarts cleanly; any pending tc_valid is ignored.

## Timing

- Fire sampled at edge E0 → tc_shoot high in the cycle after E0 → WAIT_RES from edge E1.
- tc_valid sampled at edge Ev → last_* valid after Ev.
  - Score, turn and game_over update at Ev+1.
  - busy falls at Ev+1.
- Minimum spacing between shots (tc_valid one cycle after tc_shoot): 4 cycles, fire-to-fire.
- Timeout: SCORE is entered TIMEOUT cycles after entering WAIT_RES.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Structure

- game_pkg: COORD_W=5; state enum (IDLE, LAUNCH, WAIT_RES, SCORE, OVER); TARGET_Y=5'd0.
- One sub-module, shot_watchdog, holds the clear/enable counter and timeout flag, parameterised by TIMEOUT.
- The scheduler instantiates shot_watchdog. The calculator is instantiated at the top level and wired to the tc_* ports.

## Test plan

- Reset, then p1_fire=1 while turn=0 → no tc_shoot. Then p0_fire with p0_xpos=2, rise=3, run=4, dir=1, p1_xpos=20 → one-cycle tc_shoot, tc_xpos=2, tc_target_x=20, tc_dir=1.
- Model returns tc_valid, tc_hit=1, tc_posx=20 two cycles after tc_shoot → score0=1, last_posx=20, turn=1, busy=0 one cycle after SCORE.
- Miss by p1 (tc_hit=0, tc_posx=7) → score1=0, last_posx=7, turn=0.
- No tc_valid with TIMEOUT=8 → SCORE 8 cycles into WAIT_RES, last_hit=0, last_posx=0. A late tc_valid afterwards changes nothing.
- p0 hits three times with p1 missing in between → game_over=1, winner=0, score0=3. Further fires are ignored. new_game clears scores, turn=0, IDLE.
- Assert rst=0 during WAIT_RES → all outputs 0 immediately. new_game asserted together with fire → no tc_shoot.
